// File: rtl/lfsr_gen.sv
// Single-channel LFSR with configurable width, polynomial and structure (Fibonacci/Galois),
// seed load with zero-seed protection, and on-line period measurement.
module lfsr_gen #(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      TAPS       = 8'hB8,
  parameter int unsigned           MODE       = 0,
  parameter logic [WIDTH-1:0]      RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] dout,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             lock_err
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             wrap_q, wrap_d;
  logic             lock_err_q, lock_err_d;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    if (MODE == 0) begin
      nxt = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end else begin
      nxt = {state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & TAPS);
    end
  end

  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    wrap_d         = 1'b0;
    lock_err_d     = 1'b0;
    if (load) begin
      // An all-zero seed would lock the register forever; substitute 1 and flag it.
      if (seed != '0) begin
        state_d = seed;
        ref_d   = seed;
      end else begin
        state_d    = WIDTH'(1);
        ref_d      = WIDTH'(1);
        lock_err_d = 1'b1;
      end
      cnt_d          = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
    end else if (en) begin
      state_d = nxt;
      if (nxt == ref_q) begin
        wrap_d         = 1'b1;
        period_d       = cnt_q + WIDTH'(1);
        period_valid_d = 1'b1;
        cnt_d          = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RESET_SEED;
      ref_q          <= RESET_SEED;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
      lock_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      wrap_q         <= wrap_d;
      lock_err_q     <= lock_err_d;
    end
  end

  assign dout         = state_q;
  assign bit_out      = state_q[WIDTH-1];
  assign wrap         = wrap_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen: one Fibonacci and one Galois instance.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_en = 1'b0, f_load = 1'b0;
  logic [7:0] f_seed = 8'h00;
  logic [7:0] f_dout, f_period;
  logic       f_bit, f_wrap, f_pv, f_lock;
  logic       g_en = 1'b0, g_load = 1'b0;
  logic [7:0] g_seed = 8'h00;
  logic [7:0] g_dout, g_period;
  logic       g_bit, g_wrap, g_pv, g_lock;

  int checks = 0;
  int errors = 0;
  int bad_wraps;
  logic [7:0] fib_exp [5];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(0), .RESET_SEED(8'h01)) u_fib (
    .clk(clk), .rst(rst), .en(f_en), .load(f_load), .seed(f_seed),
    .dout(f_dout), .bit_out(f_bit), .wrap(f_wrap), .period(f_period),
    .period_valid(f_pv), .lock_err(f_lock)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .MODE(1), .RESET_SEED(8'h01)) u_gal (
    .clk(clk), .rst(rst), .en(g_en), .load(g_load), .seed(g_seed),
    .dout(g_dout), .bit_out(g_bit), .wrap(g_wrap), .period(g_period),
    .period_valid(g_pv), .lock_err(g_lock)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fib_exp[0] = 8'h02; fib_exp[1] = 8'h04; fib_exp[2] = 8'h08;
    fib_exp[3] = 8'h11; fib_exp[4] = 8'h23;

    // reset state
    #12;
    chk("rst_dout", 32'(f_dout), 32'h01);
    chk("rst_period", 32'(f_period), 32'h0);
    chk("rst_pv", 32'(f_pv), 32'h0);
    chk("rst_wrap", 32'(f_wrap), 32'h0);
    chk("rst_lock", 32'(f_lock), 32'h0);
    chk("rst_bit", 32'(f_bit), 32'h0);
    chk("rst_gdout", 32'(g_dout), 32'h01);
    rst = 1'b0;
    #1;

    // Fibonacci sequence
    f_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("fib_step%0d", i + 1), 32'(f_dout), 32'(fib_exp[i]));
    end
    chk("fib_pv_early", 32'(f_pv), 32'h0);

    // period measurement: first wrap at step 255, second at 510
    bad_wraps = 0;
    for (int k = 6; k <= 510; k++) begin
      tick();
      if (k == 255 || k == 510) begin
        chk($sformatf("wrap_at_%0d", k), 32'(f_wrap), 32'h1);
        chk($sformatf("wrap_dout_%0d", k), 32'(f_dout), 32'h01);
        chk($sformatf("period_%0d", k), 32'(f_period), 32'd255);
        chk($sformatf("pv_%0d", k), 32'(f_pv), 32'h1);
      end else if (f_wrap !== 1'b0) begin
        bad_wraps++;
      end
    end
    chk("no_spurious_wrap", 32'(bad_wraps), 32'h0);

    // reset mid-operation, between clock edges
    for (int k = 0; k < 100; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(f_dout), 32'h01);
    chk("mid_rst_period", 32'(f_period), 32'h0);
    chk("mid_rst_pv", 32'(f_pv), 32'h0);
    #3;
    rst = 1'b0;
    tick();
    chk("resume_dout", 32'(f_dout), 32'h02);

    // load priority over en
    f_load = 1'b1;
    f_seed = 8'h5A;
    tick();
    chk("prio_dout", 32'(f_dout), 32'h5A);
    chk("prio_lock", 32'(f_lock), 32'h0);
    chk("prio_pv", 32'(f_pv), 32'h0);

    // hold for 10 cycles
    f_load = 1'b0;
    f_en = 1'b0;
    bad_wraps = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (f_dout !== 8'h5A || f_wrap !== 1'b0) bad_wraps++;
    end
    chk("hold_stable", 32'(bad_wraps), 32'h0);

    // cnt must not have moved while idle: next wrap still measures 255
    f_en = 1'b1;
    bad_wraps = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k < 255 && f_wrap !== 1'b0) bad_wraps++;
    end
    chk("seed_wrap", 32'(f_wrap), 32'h1);
    chk("seed_wrap_dout", 32'(f_dout), 32'h5A);
    chk("seed_period", 32'(f_period), 32'd255);
    chk("seed_no_early_wrap", 32'(bad_wraps), 32'h0);

    // zero-seed lock-up protection
    f_en = 1'b0;
    f_load = 1'b1;
    f_seed = 8'h00;
    tick();
    chk("zero_dout", 32'(f_dout), 32'h01);
    chk("zero_lock", 32'(f_lock), 32'h1);
    chk("zero_pv", 32'(f_pv), 32'h0);
    chk("zero_period", 32'(f_period), 32'h0);
    f_load = 1'b0;
    tick();
    chk("zero_lock_pulse", 32'(f_lock), 32'h0);
    chk("zero_hold", 32'(f_dout), 32'h01);

    // Galois step
    g_load = 1'b1;
    g_seed = 8'h80;
    tick();
    chk("gal_load", 32'(g_dout), 32'h80);
    chk("gal_bit", 32'(g_bit), 32'h1);
    g_load = 1'b0;
    g_en = 1'b1;
    tick();
    chk("gal_step80", 32'(g_dout), 32'h1D);
    g_en = 1'b0;
    g_load = 1'b1;
    g_seed = 8'h01;
    tick();
    g_load = 1'b0;
    g_en = 1'b1;
    tick();
    chk("gal_step01", 32'(g_dout), 32'h02);
    g_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised successor to the lab's fixed 8-bit LFSR pair: a single LFSR channel of configurable width, polynomial and structure (Fibonacci or Galois).
Adds step enable, seed load with zero-seed lock-up protection, and on-line period measurement with a wrap pulse.
Used as the pseudo-random source in later labs and self-checks its sequence length against the selected polynomial.

Parameters:
WIDTH, 8, register width in bits; legal range 3..32.
TAPS, 8'hB8, WIDTH-bit polynomial mask. Meaning depends on MODE.
MODE, 0, 0 = Fibonacci, 1 = Galois.
RESET_SEED, 1, state after reset; must be nonzero.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  advance the LFSR one step this cycle.
load  in  1  load seed this cycle; has priority over en.
seed  in  WIDTH  value taken when load=1.
dout  out  WIDTH  current LFSR state, registered.
bit_out  out  1  dout[WIDTH-1], serial output.
wrap  out  1  one-cycle pulse: the state just returned to the reference value.
period  out  WIDTH  last measured sequence length in steps.
period_valid  out  1  period holds a measurement taken since the last load or reset.
lock_err  out  1  one-cycle pulse: an all-zero seed was loaded and replaced.

Behaviour:
- Next-state function nxt(s):
  - MODE=0 (Fibonacci): nxt = {s[WIDTH-2:0], ^(s & TAPS)}, i.e. shift left and feed in the XOR of the tapped bits.
  - MODE=1 (Galois): nxt = {s[WIDTH-2:0],1'b0} ^ ({WIDTH{s[WIDTH-1]}} & TAPS).
- Invertibility requirement:
  - MODE=0 requires TAPS[WIDTH-1]=1.
  - MODE=1 requires TAPS[0]=1.
  - Any other TAPS value is illegal; behaviour is then undefined apart from cnt saturation.
- Internal registers:
  - state (drives dout).
  - ref, the reference value for period detection.
  - cnt, a WIDTH-bit step counter.
- Reset, asynchronous, applied at any time including mid-sequence:
  - state = ref = RESET_SEED.
  - cnt = 0, period = 0.
  - period_valid = 0, wrap = 0, lock_err = 0.
- Load, one edge with load=1; en is ignored that cycle:
  - If seed != 0: state = ref = seed, lock_err = 0.
  - If seed == 0: state = ref = 1, and lock_err = 1 for exactly one cycle.
  - In both cases: cnt = 0, period = 0, period_valid = 0, wrap = 0.
- Step, edge with en=1 and load=0:
  - state = nxt(state).
  - If nxt(state) == ref: wrap = 1, period = cnt+1, period_valid = 1, cnt = 0.
  - Otherwise: wrap = 0, and cnt = cnt+1, saturating at 2^WIDTH-1.
- Idle, en=0 and load=0:
  - state, cnt, period and period_valid hold.
  - wrap and lock_err are 0.
- Latency:
  - dout reflects a load or step on the same edge (one cycle after the request is sampled).
  - wrap is asserted in the same cycle dout shows the value equal to ref.
- After a wrap, measurement restarts automatically. period is overwritten at each wrap; it changes only if the sequence changes.
- An all-zero state is unreachable from reset, load or stepping when TAPS is legal.
- The maximal period is 2^WIDTH-1, which fits in period.

Test Plan:
1. Fibonacci sequence: WIDTH=8, MODE=0, TAPS=8'hB8. Reset, then en=1 for 5 cycles -> dout = 01, 02, 04, 08, 11, 23.
2. Period measurement: same config, en=1 continuously from reset -> wrap pulses exactly once every 255 cycles, with dout=8'h01 at each pulse. period=255 and period_valid=1 after the first wrap; no wrap between pulses.
3. Galois step: MODE=1, TAPS=8'h1D. load seed=8'h80, then en=1 for one cycle -> dout=8'h1D. With seed=8'h01 the same single step gives dout=8'h02.
4. Lock-up protection: load seed=0 -> next cycle dout=8'h01, lock_err=1 for one cycle, period_valid=0.
5. Priority and hold:
   - load=1 and en=1 together with seed=8'h5A -> dout=8'h5A, no step taken.
   - en=0 for 10 cycles -> dout stays 8'h5A, cnt unchanged, no wrap.
6. Reset mid-operation: after 100 steps, assert rst asynchronously between clock edges -> dout=8'h01, period=0, period_valid=0 immediately. Stepping resumes from 8'h01 after release.
